// File: rtl/rgb_pwm_driver_pkg.sv
// Shared definitions for the RGB PWM driver.
// Holds the colour-word slice positions, the PWM full-scale value and the FSM state type.
package rgb_pwm_pkg;

   localparam int R_MSB = 23;
   localparam int R_LSB = 16;
   localparam int G_MSB = 15;
   localparam int G_LSB = 8;
   localparam int B_MSB = 7;
   localparam int B_LSB = 0;

   localparam logic [7:0] PWM_MAX = 8'd255;

   typedef enum logic {
      OFF = 1'b0,
      RUN = 1'b1
   } pwm_state_t;

endpackage

// File: rtl/rgb_pwm_driver_channel.sv
// One PWM colour channel: a shadow duty register and a registered counter comparator.
// Optional macro PWM_FULL_ON_EN makes a duty of PWM_MAX hold the LED on for the whole period.
module pwm_channel
   import rgb_pwm_pkg::*;
#(
   parameter int CH_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            clear,
   input  logic [CH_W-1:0] duty,
   input  logic [CH_W-1:0] cnt,
   output logic            led
);

   logic [CH_W-1:0] duty_q, duty_d;
   logic            led_q, led_d;
   logic            hit;

`ifdef PWM_FULL_ON_EN
   assign hit = (cnt < duty_q) || (duty_q == PWM_MAX);
`else
   assign hit = (cnt < duty_q);
`endif

   // The compare always uses the duty held before a reload, so a new duty takes effect with count 0.
   always_comb begin
      duty_d = duty_q;
      led_d  = hit;
      if (clear) begin
         duty_d = '0;
         led_d  = 1'b0;
      end else if (load) begin
         duty_d = duty;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q <= '0;
         led_q  <= 1'b0;
      end else begin
         duty_q <= duty_d;
         led_q  <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver with period-aligned colour reload and a sysOn gate.
// Channel behaviour at full duty depends on the optional macro PWM_FULL_ON_EN.
module rgb_pwm_driver
   import rgb_pwm_pkg::*;
#(
   parameter int PRESCALE = 4,
   parameter int CH_W     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] colour,
   input  logic        sysOn,
   output logic        led_r,
   output logic        led_g,
   output logic        led_b,
   output logic        period_done,
   output logic        running
);

   localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   pwm_state_t        state_q, state_d;
   logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
   logic [CH_W-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic              period_done_q, period_done_d;
   logic              tick;
   logic              periodEnd;
   logic              load;
   logic              clear;

   assign tick      = (pre_cnt_q == PRE_LAST);
   assign periodEnd = tick && (pwm_cnt_q == PWM_MAX);
   assign clear     = ~sysOn;

   // A falling sysOn takes priority over a coincident period end, so no reload pulse is emitted.
   always_comb begin
      state_d       = state_q;
      pre_cnt_d     = pre_cnt_q;
      pwm_cnt_d     = pwm_cnt_q;
      period_done_d = 1'b0;
      load          = 1'b0;
      unique case (state_q)
         OFF: begin
            if (sysOn) begin
               state_d   = RUN;
               load      = 1'b1;
               pre_cnt_d = '0;
               pwm_cnt_d = '0;
            end
         end
         RUN: begin
            if (!sysOn) begin
               state_d   = OFF;
               pre_cnt_d = '0;
               pwm_cnt_d = '0;
            end else begin
               if (tick) begin
                  pre_cnt_d = '0;
                  pwm_cnt_d = pwm_cnt_q + CH_W'(1);
               end else begin
                  pre_cnt_d = pre_cnt_q + PRE_W'(1);
               end
               if (periodEnd) begin
                  load          = 1'b1;
                  period_done_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= OFF;
         pre_cnt_q     <= '0;
         pwm_cnt_q     <= '0;
         period_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pre_cnt_q     <= pre_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         period_done_q <= period_done_d;
      end
   end

   pwm_channel #(.CH_W(CH_W)) u_chan_r (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .clear (clear),
      .duty  (colour[R_MSB:R_LSB]),
      .cnt   (pwm_cnt_q),
      .led   (led_r)
   );

   pwm_channel #(.CH_W(CH_W)) u_chan_g (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .clear (clear),
      .duty  (colour[G_MSB:G_LSB]),
      .cnt   (pwm_cnt_q),
      .led   (led_g)
   );

   pwm_channel #(.CH_W(CH_W)) u_chan_b (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .clear (clear),
      .duty  (colour[B_MSB:B_LSB]),
      .cnt   (pwm_cnt_q),
      .led   (led_b)
   );

   assign period_done = period_done_q;
   assign running     = (state_q == RUN);

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: per-period on-time counts are queued as expectations
// and compared when each period's reload pulse is observed. Honours PWM_FULL_ON_EN.
module tb_rgb_pwm_driver;

   typedef struct {
      int r;
      int g;
      int b;
   } expect_t;

`ifdef PWM_FULL_ON_EN
   localparam int FULL = 256;
`else
   localparam int FULL = 255;
`endif

   logic        clk;
   logic        rst_n;
   logic [23:0] colour1, colour4;
   logic        sysOn1, sysOn4;
   logic        ledR1, ledG1, ledB1, pd1, run1;
   logic        ledR4, ledG4, ledB4, pd4, run4;

   int testsRun    = 0;
   int testsFailed = 0;
   expect_t expQ[$];

   rgb_pwm_driver #(.PRESCALE(1), .CH_W(8)) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .colour      (colour1),
      .sysOn       (sysOn1),
      .led_r       (ledR1),
      .led_g       (ledG1),
      .led_b       (ledB1),
      .period_done (pd1),
      .running     (run1)
   );

   rgb_pwm_driver #(.PRESCALE(4), .CH_W(8)) dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .colour      (colour4),
      .sysOn       (sysOn4),
      .led_r       (ledR4),
      .led_g       (ledG4),
      .led_b       (ledB4),
      .period_done (pd4),
      .running     (run4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int which, input logic on, input logic [23:0] col);
      if (which == 0) begin
         sysOn1  = on;
         colour1 = col;
      end else begin
         sysOn4  = on;
         colour4 = col;
      end
   endtask

   // Counts LED-high samples over one period and checks the reload pulse lands only on its last sample.
   task automatic measurePeriod(input int which, input int nCycles, input int changeAt,
                                input logic [23:0] newColour, input string tag);
      int      r = 0;
      int      g = 0;
      int      b = 0;
      int      pdCnt = 0;
      int      pdLast = 0;
      expect_t e;
      for (int i = 1; i <= nCycles; i++) begin
         @(negedge clk);
         if (which == 0) begin
            r += int'(ledR1); g += int'(ledG1); b += int'(ledB1);
            pdCnt += int'(pd1);
            if (i == nCycles) pdLast = int'(pd1);
            if (i == changeAt) colour1 = newColour;
         end else begin
            r += int'(ledR4); g += int'(ledG4); b += int'(ledB4);
            pdCnt += int'(pd4);
            if (i == nCycles) pdLast = int'(pd4);
         end
      end
      checkOutput({tag, "_queue"}, int'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput({tag, "_r_on"}, r, e.r);
         checkOutput({tag, "_g_on"}, g, e.g);
         checkOutput({tag, "_b_on"}, b, e.b);
      end
      checkOutput({tag, "_pd_count"}, pdCnt, 1);
      checkOutput({tag, "_pd_at_end"}, pdLast, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 1'b0, 24'h0);
      applyStimulus(1, 1'b0, 24'h0);
      repeat (3) @(negedge clk);
      checkOutput("reset_outs1", int'({ledR1, ledG1, ledB1, pd1, run1}), 0);
      checkOutput("reset_outs4", int'({ledR4, ledG4, ledB4, pd4, run4}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle_off1", int'({ledR1, ledG1, ledB1, pd1, run1}), 0);

      // Steady colour, then mid-period colour changes that must wait for the next reload.
      expQ.push_back('{r: 128, g: 0, b: FULL});
      expQ.push_back('{r: 128, g: 0, b: FULL});
      expQ.push_back('{r: 64, g: 64, b: 64});
      expQ.push_back('{r: 192, g: 192, b: 192});
      applyStimulus(0, 1'b1, 24'h80_00_FF);
      @(negedge clk);
      checkOutput("start_running", int'(run1), 1);
      checkOutput("start_leds", int'({ledR1, ledG1, ledB1, pd1}), 0);
      measurePeriod(0, 256, 0, 24'h0, "p1");
      measurePeriod(0, 256, 100, 24'h40_40_40, "p2");
      measurePeriod(0, 256, 100, 24'hC0_C0_C0, "p3");
      measurePeriod(0, 256, 0, 24'h0, "p4");

      // sysOn falls mid-period with full white loaded.
      expQ.push_back('{r: 192, g: 192, b: 192});
      colour1 = 24'hFF_FF_FF;
      measurePeriod(0, 256, 0, 24'h0, "p5");
      repeat (50) @(negedge clk);
      checkOutput("white_leds_on", int'({ledR1, ledG1, ledB1}), 7);
      sysOn1 = 1'b0;
      @(negedge clk);
      checkOutput("drop_leds_dark", int'({ledR1, ledG1, ledB1}), 0);
      checkOutput("drop_running", int'(run1), 0);
      checkOutput("drop_pd", int'(pd1), 0);
      repeat (3) @(negedge clk);
      checkOutput("off_stays_dark", int'({ledR1, ledG1, ledB1, pd1, run1}), 0);
      expQ.push_back('{r: 32, g: 0, b: 0});
      applyStimulus(0, 1'b1, 24'h20_00_00);
      @(negedge clk);
      checkOutput("restart_running", int'(run1), 1);
      measurePeriod(0, 256, 0, 24'h0, "p7");

      // Asynchronous reset in the middle of a period.
      repeat (10) @(negedge clk);
      checkOutput("pre_reset_led_r", int'(ledR1), 1);
      rst_n  = 1'b0;
      sysOn1 = 1'b0;
      #1;
      checkOutput("async_reset_outs", int'({ledR1, ledG1, ledB1, pd1, run1}), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("post_reset_off", int'({ledR1, ledG1, ledB1, pd1, run1}), 0);
      expQ.push_back('{r: 16, g: 32, b: 48});
      applyStimulus(0, 1'b1, 24'h10_20_30);
      @(negedge clk);
      checkOutput("post_reset_run", int'(run1), 1);
      measurePeriod(0, 256, 0, 24'h0, "p8");

      // sysOn falls exactly on the period-end cycle: no reload pulse, LEDs dark.
      repeat (255) @(negedge clk);
      sysOn1 = 1'b0;
      @(negedge clk);
      checkOutput("pe_drop_pd", int'(pd1), 0);
      checkOutput("pe_drop_outs", int'({ledR1, ledG1, ledB1, run1}), 0);
      repeat (5) @(negedge clk);
      checkOutput("pe_drop_dark", int'({ledR1, ledG1, ledB1, pd1, run1}), 0);

      // Prescaled instance: duty 1 lasts one step of four clocks per 1024-clock period.
      expQ.push_back('{r: 4, g: 0, b: 0});
      expQ.push_back('{r: 4, g: 0, b: 0});
      applyStimulus(1, 1'b1, 24'h01_00_00);
      @(negedge clk);
      checkOutput("ps4_running", int'(run4), 1);
      measurePeriod(1, 1024, 0, 24'h0, "ps4_p1");
      measurePeriod(1, 1024, 0, 24'h0, "ps4_p2");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
